// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle RV32I control path: FSM states,
// opcodes, ALU operations and datapath mux selects.
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        JALR     = 4'd10,
        BRANCH   = 4'd11,
        LUI      = 4'd12,
        TRAP     = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLTU  = 4'b0101;
    localparam logic [3:0] ALU_SLT   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_SLL   = 4'b1000;
    localparam logic [3:0] ALU_SRL   = 4'b1001;
    localparam logic [3:0] ALU_SRA   = 4'b1010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_PASSB = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        logic [2:0] sel;
        sel = IMM_I;
        case (op)
            OP_STORE:         sel = IMM_S;
            OP_BRANCH:        sel = IMM_B;
            OP_JAL:           sel = IMM_J;
            OP_LUI, OP_AUIPC: sel = IMM_U;
            default:          sel = IMM_I;
        endcase
        return sel;
    endfunction

    // Returns {defined, taken}; funct3 010/011 are not branch encodings.
    function automatic logic [1:0] branch_eval_of(input logic [2:0] f3,
                                                  input logic       zero,
                                                  input logic       slt,
                                                  input logic       ult);
        logic [1:0] res;
        res = 2'b00;
        case (f3)
            3'b000:  res = {1'b1, zero};
            3'b001:  res = {1'b1, ~zero};
            3'b100:  res = {1'b1, slt};
            3'b101:  res = {1'b1, ~slt};
            3'b110:  res = {1'b1, ult};
            3'b111:  res = {1'b1, ~ult};
            default: res = 2'b00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control/flag bus between the multicycle controller (master) and the
// RV32I datapath (slave).
interface multicycle_control_if;
    logic [31:0] Instr;
    logic        Zero;
    logic        signedLess;
    logic        unsignedLess;
    logic [3:0]  ALUControl;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [2:0]  ImmSrc;
    logic        AdrSrc;
    logic        IRWrite;
    logic        PCWrite;
    logic        RegWrite;
    logic        MemWrite;
    logic        illegal_instr;
    logic [3:0]  state_o;

    modport master (
        input  Instr, Zero, signedLess, unsignedLess,
        output ALUControl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
               IRWrite, PCWrite, RegWrite, MemWrite, illegal_instr, state_o
    );

    modport slave (
        output Instr, Zero, signedLess, unsignedLess,
        input  ALUControl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
               IRWrite, PCWrite, RegWrite, MemWrite, illegal_instr, state_o
    );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// ALU operation decoder: maps the FSM's coarse alu_op plus funct fields onto
// the 4-bit ALUControl, flagging R-type funct7 values outside RV32I.
module alu_decoder
    import multicycle_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       op5,
    output logic [3:0] alu_control,
    output logic       illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (alu_op)
            ALUOP_ADD:   alu_control = ALU_ADD;
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_PASSB: alu_control = ALU_PASSB;
            default: begin
                // op5 separates R-type from OP-IMM; only R-type has a real funct7
                case (funct3)
                    3'b000:  alu_control = (op5 && funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
                illegal = op5 && (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I datapath: sequences each
// instruction over 3-5 cycles and drives every datapath select and enable.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter bit RESET_TRAP = 1'b0
) (
    input logic                  clk,
    input logic                  rst,
    multicycle_control_if.master bus
);

    localparam state_t RESET_STATE = RESET_TRAP ? TRAP : FETCH;

    state_t     state_reg;
    state_t     state_next;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [1:0] branch_eval;
    logic       instr_unused;

    logic [1:0] alu_op;
    logic [3:0] alu_control;
    logic       funct_illegal;

    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       trap_flag;

    assign opcode      = bus.Instr[6:0];
    assign funct3      = bus.Instr[14:12];
    assign funct7      = bus.Instr[31:25];
    assign branch_eval = branch_eval_of(funct3, bus.Zero, bus.signedLess, bus.unsignedLess);
    // register indices and immediate bits are consumed by the datapath only
    assign instr_unused = ^{bus.Instr[24:15], bus.Instr[11:7]};

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7      (funct7),
        .op5         (opcode[5]),
        .alu_control (alu_control),
        .illegal     (funct_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RESET_STATE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        alu_op     = ALUOP_ADD;
        src_a      = SRCA_PC;
        src_b      = SRCB_RS2;
        result_src = RES_ALUOUT;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        trap_flag  = 1'b0;

        case (state_reg)
            FETCH: begin
                ir_write   = 1'b1;
                src_b      = SRCB_FOUR;
                result_src = RES_ALURESULT;
                pc_write   = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                // speculative branch/jump target: ALUOut <= OldPC + imm
                src_a = SRCA_OLDPC;
                src_b = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_R:              state_next = EXECR;
                    OP_IMM:            state_next = EXECI;
                    OP_JAL:            state_next = JAL;
                    OP_JALR:           state_next = JALR;
                    OP_BRANCH:         state_next = BRANCH;
                    OP_LUI:            state_next = LUI;
                    OP_AUIPC:          state_next = ALUWB;
                    default:           state_next = TRAP;
                endcase
            end
            MEMADR: begin
                src_a      = SRCA_RS1;
                src_b      = SRCB_IMM;
                state_next = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src    = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                state_next = FETCH;
            end
            EXECR: begin
                src_a      = SRCA_RS1;
                src_b      = SRCB_RS2;
                alu_op     = ALUOP_FUNCT;
                state_next = funct_illegal ? TRAP : ALUWB;
            end
            EXECI: begin
                src_a      = SRCA_RS1;
                src_b      = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                state_next = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            JALR: begin
                src_a      = SRCA_RS1;
                src_b      = SRCB_IMM;
                state_next = JAL;
            end
            JAL: begin
                // PC takes the target held in ALUOut while the ALU forms the link value
                src_a      = SRCA_OLDPC;
                src_b      = SRCB_FOUR;
                pc_write   = 1'b1;
                state_next = ALUWB;
            end
            BRANCH: begin
                src_a      = SRCA_RS1;
                src_b      = SRCB_RS2;
                alu_op     = ALUOP_SUB;
                pc_write   = branch_eval[1] & branch_eval[0];
                state_next = branch_eval[1] ? FETCH : TRAP;
            end
            LUI: begin
                src_b      = SRCB_IMM;
                alu_op     = ALUOP_PASSB;
                state_next = ALUWB;
            end
            TRAP: begin
                trap_flag  = 1'b1;
                state_next = TRAP;
            end
            default: begin
                state_next = TRAP;
            end
        endcase
    end

    assign bus.ALUControl    = alu_control;
    assign bus.ALUSrcA       = src_a;
    assign bus.ALUSrcB       = src_b;
    assign bus.ResultSrc     = result_src;
    assign bus.ImmSrc        = imm_src_of(opcode);
    assign bus.AdrSrc        = adr_src;
    // enables are gated by rst so nothing commits while reset is held
    assign bus.IRWrite       = ir_write  & ~rst;
    assign bus.PCWrite       = pc_write  & ~rst;
    assign bus.RegWrite      = reg_write & ~rst;
    assign bus.MemWrite      = mem_write & ~rst;
    assign bus.illegal_instr = trap_flag & ~rst;
    assign bus.state_o       = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed table, hand-written corner sequences
// and random instructions checked cycle by cycle against a trace model.
module tb_multicycle_control;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_JALR     = 4'd10;
    localparam logic [3:0] S_BRANCH   = 4'd11;
    localparam logic [3:0] S_LUI      = 4'd12;
    localparam logic [3:0] S_TRAP     = 4'd13;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] alu;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] rs;
        logic [2:0] imm;
        logic       adr;
        logic       irw;
        logic       pcw;
        logic       rw;
        logic       mw;
        logic       ill;
    } obs_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        z;
        logic        sl;
        logic        ul;
        int          cycles;
        logic [3:0]  alu2;
        logic        pcw2;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;

    multicycle_control_if bus ();
    multicycle_control_if bus2 ();

    multicycle_control #(.RESET_TRAP(1'b0)) dut (.clk(clk), .rst(rst), .bus(bus));
    multicycle_control #(.RESET_TRAP(1'b1)) dut_trap (.clk(clk), .rst(rst2), .bus(bus2));

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail = 0;
    obs_t exp_q[$];
    obs_t hist[$];
    logic exp_trap;
    logic [2:0] cur_imm;
    logic [3:0] end_state;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic obs_t obs_now();
        obs_t o;
        o.st  = bus.state_o;
        o.alu = bus.ALUControl;
        o.sa  = bus.ALUSrcA;
        o.sb  = bus.ALUSrcB;
        o.rs  = bus.ResultSrc;
        o.imm = bus.ImmSrc;
        o.adr = bus.AdrSrc;
        o.irw = bus.IRWrite;
        o.pcw = bus.PCWrite;
        o.rw  = bus.RegWrite;
        o.mw  = bus.MemWrite;
        o.ill = bus.illegal_instr;
        return o;
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        if (op == 7'h23) return 3'd1;
        if (op == 7'h63) return 3'd2;
        if (op == 7'h6F) return 3'd3;
        if (op == 7'h37 || op == 7'h17) return 3'd4;
        return 3'd0;
    endfunction

    // en = {AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite}
    function automatic obs_t make(input logic [3:0] st, input logic [3:0] alu, input logic [1:0] sa,
                                  input logic [1:0] sb, input logic [1:0] rs, input logic [4:0] en);
        obs_t o;
        o.st  = st;
        o.alu = alu;
        o.sa  = sa;
        o.sb  = sb;
        o.rs  = rs;
        o.imm = cur_imm;
        {o.adr, o.irw, o.pcw, o.rw, o.mw} = en;
        o.ill = (st == S_TRAP);
        return o;
    endfunction

    function automatic void push(input logic [3:0] st, input logic [3:0] alu, input logic [1:0] sa,
                                 input logic [1:0] sb, input logic [1:0] rs, input logic [4:0] en);
        exp_q.push_back(make(st, alu, sa, sb, rs, en));
    endfunction

    function automatic logic [3:0] funct_alu(input logic [31:0] ins);
        logic [3:0] tbl [0:7];
        logic [3:0] a;
        logic [2:0] f3;
        tbl = '{4'h0, 4'h8, 4'h6, 4'h5, 4'h4, 4'h9, 4'h3, 4'h2};
        f3 = ins[14:12];
        a = tbl[f3];
        if (f3 == 3'd0 && ins[5] && ins[30]) a = 4'h1;
        if (f3 == 3'd5 && ins[30]) a = 4'hA;
        return a;
    endfunction

    // Expected per-cycle observation list for one instruction, from FETCH onward.
    function automatic void build_trace(input logic [31:0] ins, input logic z, input logic sl,
                                        input logic ul, input int ntrap);
        logic [6:0] op;
        logic [2:0] f3;
        logic       base;
        logic       taken;
        op = ins[6:0];
        f3 = ins[14:12];
        cur_imm = imm_of(op);
        exp_trap = 1'b0;
        exp_q.delete();
        push(S_FETCH, 4'h0, 2'd0, 2'd2, 2'd2, 5'b01100);
        push(S_DECODE, 4'h0, 2'd1, 2'd1, 2'd0, 5'b00000);
        case (op)
            7'h03: begin
                push(S_MEMADR, 4'h0, 2'd2, 2'd1, 2'd0, 5'b00000);
                push(S_MEMREAD, 4'h0, 2'd0, 2'd0, 2'd0, 5'b10000);
                push(S_MEMWB, 4'h0, 2'd0, 2'd0, 2'd1, 5'b00010);
            end
            7'h23: begin
                push(S_MEMADR, 4'h0, 2'd2, 2'd1, 2'd0, 5'b00000);
                push(S_MEMWRITE, 4'h0, 2'd0, 2'd0, 2'd0, 5'b10001);
            end
            7'h33: begin
                push(S_EXECR, funct_alu(ins), 2'd2, 2'd0, 2'd0, 5'b00000);
                if (ins[31:25] != 7'h00 && ins[31:25] != 7'h20) exp_trap = 1'b1;
                else push(S_ALUWB, 4'h0, 2'd0, 2'd0, 2'd0, 5'b00010);
            end
            7'h13: begin
                push(S_EXECI, funct_alu(ins), 2'd2, 2'd1, 2'd0, 5'b00000);
                push(S_ALUWB, 4'h0, 2'd0, 2'd0, 2'd0, 5'b00010);
            end
            7'h6F: begin
                push(S_JAL, 4'h0, 2'd1, 2'd2, 2'd0, 5'b00100);
                push(S_ALUWB, 4'h0, 2'd0, 2'd0, 2'd0, 5'b00010);
            end
            7'h67: begin
                push(S_JALR, 4'h0, 2'd2, 2'd1, 2'd0, 5'b00000);
                push(S_JAL, 4'h0, 2'd1, 2'd2, 2'd0, 5'b00100);
                push(S_ALUWB, 4'h0, 2'd0, 2'd0, 2'd0, 5'b00010);
            end
            7'h63: begin
                base  = f3[2] ? (f3[1] ? ul : sl) : z;
                taken = base ^ f3[0];
                if (f3 == 3'd2 || f3 == 3'd3) begin
                    exp_trap = 1'b1;
                    taken = 1'b0;
                end
                push(S_BRANCH, 4'h1, 2'd2, 2'd0, 2'd0, {2'b00, taken, 2'b00});
            end
            7'h37: begin
                push(S_LUI, 4'h7, 2'd0, 2'd1, 2'd0, 5'b00000);
                push(S_ALUWB, 4'h0, 2'd0, 2'd0, 2'd0, 5'b00010);
            end
            7'h17: push(S_ALUWB, 4'h0, 2'd0, 2'd0, 2'd0, 5'b00010);
            default: exp_trap = 1'b1;
        endcase
        if (exp_trap) begin
            for (int i = 0; i < ntrap; i++) push(S_TRAP, 4'h0, 2'd0, 2'd0, 2'd0, 5'b00000);
        end
    endfunction

    // Called at a falling edge; asserts rst, checks the held-reset outputs, releases.
    task automatic do_reset(input string name);
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs_now() !== make(S_FETCH, 4'h0, 2'd0, 2'd2, 2'd2, 5'b00000)) begin
            n_fail++;
            $display("FAIL %s.rst: got %h expected %h", name, obs_now(),
                     make(S_FETCH, 4'h0, 2'd0, 2'd2, 2'd2, 5'b00000));
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a falling edge with the FSM in FETCH; returns at the next FETCH.
    task automatic run_instr(input string name, input logic [31:0] ins, input logic z,
                             input logic sl, input logic ul, input int ntrap);
        obs_t o;
        build_trace(ins, z, sl, ul, ntrap);
        bus.Instr = ins;
        bus.Zero = z;
        bus.signedLess = sl;
        bus.unsignedLess = ul;
        hist.delete();
        foreach (exp_q[i]) begin
            #1;
            o = obs_now();
            hist.push_back(o);
            n_checks++;
            if (o !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s.c%0d: got %h expected %h", name, i, o, exp_q[i]);
            end
            @(negedge clk);
        end
        end_state = bus.state_o;
        $display("txn %s instr=%08h z=%0b sl=%0b ul=%0b cycles=%0d trap=%0b",
                 name, ins, z, sl, ul, hist.size(), exp_trap);
        if (exp_trap) do_reset(name);
        else check_val({name, ".end"}, {28'd0, end_state}, {28'd0, S_FETCH});
    endtask

    vec_t vecs [12];

    initial begin
        int         dut_cycles;
        logic [31:0] ins;
        logic [6:0] op;

        vecs[0]  = '{"add",   32'h002081B3, 1'b0, 1'b0, 1'b0, 4, 4'h0, 1'b0};
        vecs[1]  = '{"lw",    32'h0000A183, 1'b0, 1'b0, 1'b0, 5, 4'h0, 1'b0};
        vecs[2]  = '{"sw",    32'h0030A023, 1'b0, 1'b0, 1'b0, 4, 4'h0, 1'b0};
        vecs[3]  = '{"beq",   32'h00208063, 1'b1, 1'b1, 1'b0, 3, 4'h1, 1'b1};
        vecs[4]  = '{"bne",   32'h00209063, 1'b1, 1'b1, 1'b0, 3, 4'h1, 1'b0};
        vecs[5]  = '{"blt",   32'h0020C063, 1'b1, 1'b1, 1'b0, 3, 4'h1, 1'b1};
        vecs[6]  = '{"bgeu",  32'h0020F063, 1'b1, 1'b1, 1'b0, 3, 4'h1, 1'b1};
        vecs[7]  = '{"sra",   32'h4020D1B3, 1'b0, 1'b0, 1'b0, 4, 4'hA, 1'b0};
        vecs[8]  = '{"srai",  32'h4030D193, 1'b0, 1'b0, 1'b0, 4, 4'hA, 1'b0};
        vecs[9]  = '{"srli",  32'h0030D193, 1'b0, 1'b0, 1'b0, 4, 4'h9, 1'b0};
        vecs[10] = '{"addi30",32'h40008193, 1'b0, 1'b0, 1'b0, 4, 4'h0, 1'b0};
        vecs[11] = '{"jalr",  32'h000080E7, 1'b0, 1'b0, 1'b0, 5, 4'h0, 1'b0};

        bus.Instr = 32'd0;
        bus.Zero = 1'b0;
        bus.signedLess = 1'b0;
        bus.unsignedLess = 1'b0;
        bus2.Instr = 32'd0;
        bus2.Zero = 1'b0;
        bus2.signedLess = 1'b0;
        bus2.unsignedLess = 1'b0;
        cur_imm = 3'd0;

        // reset state of both instances
        repeat (2) @(negedge clk);
        #1;
        check_val("reset.obs", {9'd0, obs_now()},
                  {9'd0, make(S_FETCH, 4'h0, 2'd0, 2'd2, 2'd2, 5'b00000)});
        check_val("rtrap.state", {28'd0, bus2.state_o}, {28'd0, S_TRAP});
        check_val("rtrap.ill_in_rst", {31'd0, bus2.illegal_instr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rst2 = 1'b0;

        // directed table
        foreach (vecs[v]) begin
            run_instr(vecs[v].name, vecs[v].instr, vecs[v].z, vecs[v].sl, vecs[v].ul, 2);
            dut_cycles = (end_state == S_FETCH) ? hist.size() : 99;
            for (int i = hist.size() - 1; i >= 1; i--)
                if (hist[i].st == S_FETCH) dut_cycles = i;
            check_val({vecs[v].name, ".cycles"}, dut_cycles, vecs[v].cycles);
            check_val({vecs[v].name, ".alu2"}, {28'd0, hist[2].alu}, {28'd0, vecs[v].alu2});
            check_val({vecs[v].name, ".pcw2"}, {31'd0, hist[2].pcw}, {31'd0, vecs[v].pcw2});
        end

        check_val("rtrap.state_run", {28'd0, bus2.state_o}, {28'd0, S_TRAP});
        check_val("rtrap.ill_run", {31'd0, bus2.illegal_instr}, 32'd1);
        check_val("rtrap.irw_run", {31'd0, bus2.IRWrite}, 32'd0);

        // illegal opcode: TRAP held for 10 cycles, cleared by reset
        run_instr("ill7f", 32'h0000007F, 1'b0, 1'b0, 1'b0, 10);
        run_instr("bad_f7", 32'h022081B3, 1'b0, 1'b0, 1'b0, 3);
        run_instr("br_f3_2", 32'h0020A063, 1'b1, 1'b0, 1'b0, 3);

        // reset in the middle of a store's MEMWRITE cycle
        bus.Instr = 32'h0030A023;
        repeat (3) @(negedge clk);
        #1;
        check_val("midst.state_before", {28'd0, bus.state_o}, {28'd0, S_MEMWRITE});
        check_val("midst.mw_before", {31'd0, bus.MemWrite}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check_val("midst.mw_forced", {31'd0, bus.MemWrite}, 32'd0);
        check_val("midst.state", {28'd0, bus.state_o}, {28'd0, S_FETCH});
        @(negedge clk);
        rst = 1'b0;
        $display("txn midst_reset instr=%08h", 32'h0030A023);
        run_instr("after_rst", 32'h002081B3, 1'b0, 1'b0, 1'b0, 2);

        // random instructions against the trace model
        for (int k = 0; k < 150; k++) begin
            ins = $urandom;
            case ($urandom_range(0, 9))
                0: op = 7'h03;
                1: op = 7'h23;
                2: op = 7'h33;
                3: op = 7'h13;
                4: op = 7'h6F;
                5: op = 7'h67;
                6: op = 7'h63;
                7: op = 7'h37;
                8: op = 7'h17;
                default: op = 7'($urandom_range(0, 127));
            endcase
            ins[6:0] = op;
            if (op == 7'h33 && $urandom_range(0, 3) != 0)
                ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            run_instr($sformatf("rnd%0d", k), ins, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
